// File: rtl/vram_slot_arbiter_if.sv
// Game-logic request/response channel into the VRAM slot arbiter.
// The game engine is the master; the arbiter is the slave.
interface vram_slot_arbiter_if #(
  parameter int AW = 17,
  parameter int DW = 8
);
  logic          g_valid;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic          g_ready;
  logic [DW-1:0] g_rdata;
  logic          g_rvalid;

  modport master (
    output g_valid, g_we, g_addr, g_wdata,
    input  g_ready, g_rdata, g_rvalid
  );

  modport slave (
    input  g_valid, g_we, g_addr, g_wdata,
    output g_ready, g_rdata, g_rvalid
  );
endinterface

// File: rtl/vram_slot_arbiter.sv
// Shares one single-port VRAM between VGA scanout and game logic.
// Slot 0 of each pixel period belongs to the display while disp_en is high.
module vram_slot_arbiter #(
  parameter int AW    = 17,
  parameter int DW    = 8,
  parameter int SLOTS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          disp_en,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_data_valid,
  vram_slot_arbiter_if.slave game,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          phase_err
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  logic [SW-1:0] slot;
  logic          dgrant;
  logic          gaccept;
  logic          tag1_disp, tag1_rd;
  logic          tag2_disp, tag2_rd;

  always_comb begin
    dgrant  = (slot == '0) && disp_en;
    gaccept = game.g_valid && !dgrant;
  end

  // g_ready must never look at g_valid, so it comes from the slot alone.
  assign game.g_ready  = !dgrant;
  assign game.g_rdata  = mem_rdata;
  assign game.g_rvalid = tag2_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot      <= LAST_SLOT;
      phase_err <= 1'b0;
    end else begin
      if (tick) begin
        slot <= '0;
        if (slot != LAST_SLOT) begin
          phase_err <= 1'b1;
        end
      end else begin
        slot <= slot + SW'(1);
      end
    end
  end

  // The winner of cycle N is presented to the RAM in N+1; idle cycles hold address/data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= dgrant || gaccept;
      mem_we <= gaccept && game.g_we;
      if (dgrant) begin
        mem_addr <= disp_addr;
      end else if (gaccept) begin
        mem_addr <= game.g_addr;
      end
      if (gaccept && game.g_we) begin
        mem_wdata <= game.g_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag1_disp <= 1'b0;
      tag1_rd   <= 1'b0;
      tag2_disp <= 1'b0;
      tag2_rd   <= 1'b0;
    end else begin
      tag1_disp <= dgrant;
      tag1_rd   <= gaccept && !game.g_we;
      tag2_disp <= tag1_disp;
      tag2_rd   <= tag1_rd;
    end
  end

  // Display words are captured so scanout sees a stable value until the next fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_data       <= '0;
      disp_data_valid <= 1'b0;
    end else begin
      disp_data_valid <= tag2_disp;
      if (tag2_disp) begin
        disp_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Self-checking bench for vram_slot_arbiter: vector table, directed corner cases,
// then random traffic against a queue-based reference model with a shadow memory.
module tb_vram_slot_arbiter;
  localparam int AW    = 17;
  localparam int DW    = 8;
  localparam int SLOTS = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic          tick;
  logic          disp_en;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_data_valid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          phase_err;

  vram_slot_arbiter_if #(.AW(AW), .DW(DW)) gif ();

  vram_slot_arbiter #(.AW(AW), .DW(DW), .SLOTS(SLOTS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .disp_en(disp_en), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_data_valid(disp_data_valid), .game(gif.slave),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .phase_err(phase_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first synchronous single-port RAM.
  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] = mem_wdata;
        mem_rdata <= mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Reference model state
  typedef struct { int due; logic [DW-1:0] data; } ret_t;
  logic [DW-1:0] shadow [0:DEPTH-1];
  ret_t          rd_q[$];
  ret_t          disp_q[$];
  int            cyc;
  int            m_slot;
  bit            m_perr;
  bit            e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] e_disp_data;
  int            tests, fails;

  typedef struct {
    logic tick, de, gv;
    logic ready, en, dvalid, rvalid, disp_cmd;
  } vec_t;
  vec_t vecs [11];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_slot = SLOTS - 1;
    m_perr = 1'b0;
    rd_q.delete();
    disp_q.delete();
    e_en = 1'b0;
    e_we = 1'b0;
    e_addr = '0;
    e_wdata = '0;
    e_disp_data = '0;
  endfunction

  task automatic apply_stimulus(input logic t, input logic de, input logic [AW-1:0] da,
                                input logic gv, input logic gw, input logic [AW-1:0] ga,
                                input logic [DW-1:0] gd);
    tick        = t;
    disp_en     = de;
    disp_addr   = da;
    gif.g_valid = gv;
    gif.g_we    = gw;
    gif.g_addr  = ga;
    gif.g_wdata = gd;
    #1;
  endtask

  // Compare this cycle against the model, then advance the model across the clock edge.
  task automatic model_step();
    bit dg, gacc, exp_rv, exp_dv;
    check_output("g_ready", gif.g_ready, !(m_slot == 0 && disp_en));
    check_output("mem_en", mem_en, e_en);
    if (e_en) begin
      check_output("mem_we", mem_we, e_we);
      check_output("mem_addr", mem_addr, e_addr);
      if (e_we) check_output("mem_wdata", mem_wdata, e_wdata);
    end
    exp_rv = (rd_q.size() > 0) && (rd_q[0].due == cyc);
    check_output("g_rvalid", gif.g_rvalid, exp_rv);
    if (exp_rv) begin
      check_output("g_rdata", gif.g_rdata, rd_q[0].data);
      void'(rd_q.pop_front());
    end
    exp_dv = (disp_q.size() > 0) && (disp_q[0].due == cyc);
    if (exp_dv) begin
      e_disp_data = disp_q[0].data;
      void'(disp_q.pop_front());
    end
    check_output("disp_data_valid", disp_data_valid, exp_dv);
    check_output("disp_data", disp_data, e_disp_data);
    check_output("phase_err", phase_err, m_perr);

    dg   = (m_slot == 0) && disp_en;
    gacc = gif.g_valid && !dg;
    e_en = dg || gacc;
    e_we = gacc && gif.g_we;
    if (dg) e_addr = disp_addr;
    else if (gacc) e_addr = gif.g_addr;
    if (gacc && gif.g_we) e_wdata = gif.g_wdata;
    if (dg) begin
      disp_q.push_back('{due: cyc + 3, data: shadow[disp_addr]});
    end else if (gacc) begin
      if (gif.g_we) shadow[gif.g_addr] = gif.g_wdata;
      else rd_q.push_back('{due: cyc + 2, data: shadow[gif.g_addr]});
    end
    if (tick && m_slot != SLOTS - 1) m_perr = 1'b1;
    m_slot = tick ? 0 : (m_slot + 1) % SLOTS;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_cycle(input logic de, input logic gv, input logic gw,
                           input logic [AW-1:0] ga, input logic [DW-1:0] gd);
    apply_stimulus(m_slot == SLOTS - 1, de, 17'h00010, gv, gw, ga, gd);
    model_step();
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 1'b0, 17'h00010, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("rst mem_en", mem_en, 0);
    check_output("rst mem_we", mem_we, 0);
    check_output("rst mem_addr", mem_addr, 0);
    check_output("rst mem_wdata", mem_wdata, 0);
    check_output("rst disp_data", disp_data, 0);
    check_output("rst disp_data_valid", disp_data_valid, 0);
    check_output("rst g_rvalid", gif.g_rvalid, 0);
    check_output("rst phase_err", phase_err, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int acc, dv_cnt, rv_cnt;
    logic de_r;
    logic [AW-1:0] ra;
    reset = 1'b1;
    tests = 0;
    fails = 0;
    cyc   = 0;
    tick = 0; disp_en = 0; disp_addr = '0;
    gif.g_valid = 0; gif.g_we = 0; gif.g_addr = '0; gif.g_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    ram[16]    = 8'hA5;
    shadow[16] = 8'hA5;

    vecs[0]  = '{1,1,0, 1,0,0,0,0};
    vecs[1]  = '{0,1,1, 0,0,0,0,0};
    vecs[2]  = '{0,1,1, 1,1,0,0,1};
    vecs[3]  = '{0,1,0, 1,1,0,0,0};
    vecs[4]  = '{1,1,0, 1,0,1,1,0};
    vecs[5]  = '{0,0,1, 1,0,0,0,0};
    vecs[6]  = '{0,0,0, 1,1,0,0,0};
    vecs[7]  = '{0,1,0, 1,0,0,1,0};
    vecs[8]  = '{0,1,0, 1,0,0,0,0};
    vecs[9]  = '{0,1,0, 0,0,0,0,0};
    vecs[10] = '{0,1,0, 1,1,0,0,1};

    @(negedge clk);
    do_reset();

    // Vector table: display fetch of RAM[0x10]=0xA5 plus interleaved game reads.
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].tick, vecs[i].de, 17'h00010, vecs[i].gv, 1'b0, 17'h00123, '0);
      check_output($sformatf("vec%0d g_ready", i), gif.g_ready, vecs[i].ready);
      check_output($sformatf("vec%0d mem_en", i), mem_en, vecs[i].en);
      check_output($sformatf("vec%0d disp_data_valid", i), disp_data_valid, vecs[i].dvalid);
      check_output($sformatf("vec%0d g_rvalid", i), gif.g_rvalid, vecs[i].rvalid);
      if (vecs[i].dvalid) check_output($sformatf("vec%0d disp_data", i), disp_data, 8'hA5);
      if (vecs[i].disp_cmd) begin
        check_output($sformatf("vec%0d disp addr", i), mem_addr, 17'h00010);
        check_output($sformatf("vec%0d disp we", i), mem_we, 0);
      end
      model_step();
    end

    // Active video with a continuously valid game port: 3 accepts per pixel.
    for (int k = 0; k < 8 && m_slot != 0; k++) run_cycle(1'b1, 1'b0, 1'b0, '0, '0);
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(m_slot == SLOTS - 1, 1'b1, 17'h00010, 1'b1, 1'b0, 17'(16'h0100 + k), '0);
      if (gif.g_ready && gif.g_valid) acc++;
      model_step();
    end
    check_output("active accepts per 2 pixels", acc, 6);

    // Blanking: every cycle goes to the game, no display pulses.
    for (int k = 0; k < 4; k++) run_cycle(1'b0, 1'b0, 1'b0, '0, '0);
    acc = 0;
    dv_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      apply_stimulus(m_slot == SLOTS - 1, 1'b0, 17'h00010, 1'b1, k[0], 17'(k), 8'(k * 7));
      if (gif.g_ready && gif.g_valid) acc++;
      if (disp_data_valid) dv_cnt++;
      model_step();
    end
    check_output("blanking accepts", acc, 16);
    check_output("blanking disp pulses", dv_cnt, 0);

    // Read-after-write at the top address.
    run_cycle(1'b0, 1'b1, 1'b1, 17'h1FFFF, 8'h3C);
    run_cycle(1'b0, 1'b1, 1'b0, 17'h1FFFF, 8'h00);
    run_cycle(1'b0, 1'b0, 1'b0, '0, '0);
    apply_stimulus(m_slot == SLOTS - 1, 1'b0, 17'h00010, 1'b0, 1'b0, '0, '0);
    check_output("raw g_rvalid", gif.g_rvalid, 1);
    check_output("raw g_rdata", gif.g_rdata, 8'h3C);
    model_step();

    // Mistimed tick at slot 1 resyncs and latches phase_err.
    for (int k = 0; k < 8 && m_slot != 1; k++) run_cycle(1'b0, 1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b1, 1'b0, 17'h00010, 1'b0, 1'b0, '0, '0);
    model_step();
    apply_stimulus(1'b0, 1'b1, 17'h00010, 1'b0, 1'b0, '0, '0);
    check_output("resync slot0 g_ready", gif.g_ready, 0);
    check_output("phase_err set", phase_err, 1);
    model_step();
    for (int k = 0; k < 10; k++) run_cycle(1'b1, 1'b0, 1'b0, '0, '0);
    check_output("phase_err sticky", phase_err, 1);
    do_reset();

    // Reset one cycle after a game read is accepted drops the response.
    for (int k = 0; k < 4; k++) run_cycle(1'b0, 1'b0, 1'b0, '0, '0);
    run_cycle(1'b0, 1'b1, 1'b0, 17'h00040, '0);
    do_reset();
    rv_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(m_slot == SLOTS - 1, 1'b0, 17'h00010, 1'b0, 1'b0, '0, '0);
      if (gif.g_rvalid) rv_cnt++;
      model_step();
    end
    check_output("no g_rvalid after reset", rv_cnt, 0);

    // Random traffic against the reference model.
    de_r = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if (k % 32 == 0) de_r = ($urandom_range(0, 3) != 0);
      ra = ($urandom_range(0, 7) == 0) ? 17'($urandom) : 17'($urandom_range(0, 15));
      apply_stimulus((m_slot == SLOTS - 1) ^ ($urandom_range(0, 99) == 0), de_r,
                     17'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                     1'($urandom), ra, 8'($urandom));
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
